// File: rtl/zet_fetch_port_if.sv
// Read-only 16-bit Wishbone link between the fetch port and the memory arbiter.
//   wb_adr_o  word address (byte address [19:1])
//   wb_sel_o  byte selects, always both lanes
//   wb_cyc_o  bus cycle active
//   wb_stb_o  strobe, tracks wb_cyc_o
//   wb_dat_i  little-endian read data
//   wb_ack_i  read data valid / cycle end
// master: the fetch port side; slave: the arbiter/memory side.
interface zet_fetch_port_if;
    localparam int unsigned ADR_W = 19;
    localparam int unsigned DAT_W = 16;
    localparam int unsigned SEL_W = 2;

    logic [ADR_W-1:0] wb_adr_o;
    logic [SEL_W-1:0] wb_sel_o;
    logic             wb_cyc_o;
    logic             wb_stb_o;
    logic [DAT_W-1:0] wb_dat_i;
    logic             wb_ack_i;

    modport master (
        output wb_adr_o,
        output wb_sel_o,
        output wb_cyc_o,
        output wb_stb_o,
        input  wb_dat_i,
        input  wb_ack_i
    );

    modport slave (
        input  wb_adr_o,
        input  wb_sel_o,
        input  wb_cyc_o,
        input  wb_stb_o,
        output wb_dat_i,
        output wb_ack_i
    );
endinterface

// File: rtl/zet_fetch_port.sv
// Instruction-byte server for the Zet fetch/decode unit.
// Serves {pc, bytefetch} requests from a two-word line buffer (words B and B+1),
// refilled over a read-only Wishbone master port. Hits are answered in the same
// cycle; block is held high until the requested bytes are present.
//   clk        system clock
//   rst        synchronous reset, active high
//   fetch_en   fetch unit is requesting bytes this cycle
//   pc         linear byte address of the first requested byte
//   bytefetch  1: one byte requested; 0: two bytes (pc, pc+1)
//   flush      IP/CS written; invalidates the buffer
//   data       [7:0] byte at pc, [15:8] byte at pc+1 (zero for byte fetches)
//   block      request not yet satisfiable
//   wb         Wishbone master (see zet_fetch_port_if)
// PREFETCH: when non-zero, idle cycles fill the word after the buffer base.
module zet_fetch_port #(
    parameter int unsigned PREFETCH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_en,
    input  logic [19:0]      pc,
    input  logic             bytefetch,
    input  logic             flush,
    output logic [15:0]      data,
    output logic             block,
    zet_fetch_port_if.master wb
);
    localparam int unsigned AW    = 20;
    localparam int unsigned WAW   = AW - 1;
    localparam int unsigned DW    = 16;
    localparam int unsigned BW    = 8;
    localparam bit          PF_EN = (PREFETCH != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_DROP
    } state_t;

    state_t         state;
    logic [WAW-1:0] b_tag;
    logic [DW-1:0]  w0;
    logic [DW-1:0]  w1;
    logic           v0;
    logic           v1;
    logic           tgt;
    logic [WAW-1:0] adr_q;
    logic           cyc_q;

    logic [WAW-1:0] b_inc;
    logic [AW-1:0]  pc1;
    logic [WAW-1:0] pc_w;
    logic [WAW-1:0] pc1_w;
    logic           lo_in0;
    logic           lo_in1;
    logic           hi_in0;
    logic           hi_in1;
    logic           lo_hit;
    logic           hi_hit;
    logic [DW-1:0]  lo_word;
    logic [DW-1:0]  hi_word;
    logic [BW-1:0]  lo_byte;
    logic [BW-1:0]  hi_byte;
    logic           need_hi;
    logic           slide;
    logic           pf_req;

    // Buffer lookup for the byte at pc and the byte at pc+1 (both wrap modulo the space).
    always_comb begin
        b_inc   = b_tag + WAW'(1);
        pc1     = pc + AW'(1);
        pc_w    = pc[AW-1:1];
        pc1_w   = pc1[AW-1:1];

        lo_in0  = (pc_w == b_tag) & v0;
        lo_in1  = (pc_w == b_inc) & v1;
        hi_in0  = (pc1_w == b_tag) & v0;
        hi_in1  = (pc1_w == b_inc) & v1;
        lo_hit  = lo_in0 | lo_in1;
        hi_hit  = hi_in0 | hi_in1;

        lo_word = lo_in0 ? w0 : w1;
        hi_word = hi_in0 ? w0 : w1;
        lo_byte = pc[0]  ? lo_word[DW-1:BW] : lo_word[BW-1:0];
        hi_byte = pc1[0] ? hi_word[DW-1:BW] : hi_word[BW-1:0];

        // Odd word fetch whose first byte sits in w0 and whose second byte is in the missing B+1.
        need_hi = fetch_en & ~bytefetch & lo_in0 & ~hi_hit;
        // pc has moved into w1: shift the window forward. This also covers an odd word
        // fetch at the top of w1 whose second byte lies in B+2, which can only be
        // reached by sliding first and then filling the new B+1.
        slide   = fetch_en & lo_in1;
        pf_req  = PF_EN & v0 & ~v1;
    end

    // Fetch-side response: zero wait states on a hit.
    always_comb begin
        block = rst | (fetch_en & ~(lo_hit & (bytefetch | hi_hit)));
        data  = '0;
        if (fetch_en) begin
            data = {(bytefetch ? BW'(0) : hi_byte), lo_byte};
        end
    end

    assign wb.wb_adr_o = adr_q;
    assign wb.wb_sel_o = 2'b11;
    assign wb.wb_cyc_o = cyc_q;
    assign wb.wb_stb_o = cyc_q;

    // Buffer and bus-cycle controller.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            b_tag <= '0;
            w0    <= '0;
            w1    <= '0;
            v0    <= 1'b0;
            v1    <= 1'b0;
            tgt   <= 1'b0;
            adr_q <= '0;
            cyc_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (flush) begin
                        // Invalidate only; the new target is fetched once flush drops.
                        v0 <= 1'b0;
                        v1 <= 1'b0;
                    end else if (fetch_en & ~lo_hit) begin
                        // Cold miss: rebase the window on the requested word.
                        b_tag <= pc_w;
                        v0    <= 1'b0;
                        v1    <= 1'b0;
                        tgt   <= 1'b0;
                        adr_q <= pc_w;
                        cyc_q <= 1'b1;
                        state <= S_RD;
                    end else if (need_hi) begin
                        tgt   <= 1'b1;
                        adr_q <= b_inc;
                        cyc_q <= 1'b1;
                        state <= S_RD;
                    end else if (slide) begin
                        b_tag <= b_inc;
                        w0    <= w1;
                        v1    <= 1'b0;
                    end else if (pf_req) begin
                        tgt   <= 1'b1;
                        adr_q <= b_inc;
                        cyc_q <= 1'b1;
                        state <= S_RD;
                    end
                end

                S_RD: begin
                    if (wb.wb_ack_i) begin
                        cyc_q <= 1'b0;
                        state <= S_IDLE;
                        if (flush) begin
                            // Data belongs to the old stream; discard it.
                            v0 <= 1'b0;
                            v1 <= 1'b0;
                        end else if (tgt) begin
                            w1 <= wb.wb_dat_i;
                            v1 <= 1'b1;
                        end else begin
                            w0 <= wb.wb_dat_i;
                            v0 <= 1'b1;
                        end
                    end else if (flush) begin
                        // The cycle must still complete; its data will be dropped.
                        v0    <= 1'b0;
                        v1    <= 1'b0;
                        state <= S_DROP;
                    end
                end

                S_DROP: begin
                    if (flush) begin
                        v0 <= 1'b0;
                        v1 <= 1'b0;
                    end
                    if (wb.wb_ack_i) begin
                        cyc_q <= 1'b0;
                        state <= S_IDLE;
                    end
                end

                default: begin
                    cyc_q <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_zet_fetch_port.sv
// Bench for zet_fetch_port: a fetch-unit driver, a Wishbone memory slave with
// selectable latency, and a scoreboard monitor comparing served bytes with a
// byte-addressed memory model.
module tb_zet_fetch_port;
    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic [19:0] pc;
    logic        bytefetch;
    logic        flush;
    logic [15:0] data;
    logic        block;

    zet_fetch_port_if wb ();

    zet_fetch_port #(.PREFETCH(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .fetch_en  (fetch_en),
        .pc        (pc),
        .bytefetch (bytefetch),
        .flush     (flush),
        .data      (data),
        .block     (block),
        .wb        (wb)
    );

    int checks = 0;
    int errors = 0;
    int lat    = 0;

    logic [15:0] exp_q[$];
    logic [18:0] rd_log[$];
    logic [15:0] mem_ovr[bit [18:0]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Memory model: a fixed hash of the word address unless overwritten.
    function automatic logic [15:0] mem_rd(input bit [18:0] w);
        if (mem_ovr.exists(w)) return mem_ovr[w];
        return 16'(w * 19'd105653) ^ 16'h5A3C;
    endfunction

    function automatic logic [7:0] byte_at(input logic [19:0] a);
        logic [15:0] wd;
        wd = mem_rd(a[19:1]);
        return a[0] ? wd[15:8] : wd[7:0];
    endfunction

    function automatic logic [15:0] model(input logic [19:0] a, input bit bf);
        logic [19:0] a1;
        a1 = a + 20'd1;
        return bf ? {8'h00, byte_at(a)} : {byte_at(a1), byte_at(a)};
    endfunction

    function automatic logic [31:0] log_at(input int i);
        if (i < rd_log.size()) return {13'd0, rd_log[i]};
        return 32'hDEAD_BEEF;
    endfunction

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Wishbone slave: data is captured at cycle start, ack after lat extra cycles.
    initial begin : slave
        bit          busy;
        int          cnt;
        logic [15:0] cap;
        busy = 0;
        cnt  = 0;
        cap  = '0;
        wb.wb_ack_i = 1'b0;
        wb.wb_dat_i = '0;
        forever begin
            @(posedge clk);
            #2;
            if (rst || wb.wb_ack_i) begin
                wb.wb_ack_i = 1'b0;
                busy = 0;
            end else begin
                if (wb.wb_cyc_o && !busy) begin
                    busy = 1;
                    cnt  = lat;
                    cap  = mem_rd(wb.wb_adr_o);
                    rd_log.push_back(wb.wb_adr_o);
                end
                if (busy) begin
                    if (cnt == 0) begin
                        wb.wb_ack_i = 1'b1;
                        wb.wb_dat_i = cap;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    // Scoreboard monitor and bus protocol checks.
    initial begin : monitor
        logic        p_cyc;
        logic        p_ack;
        logic        p_rst;
        logic [18:0] p_adr;
        logic [15:0] e;
        p_cyc = 0;
        p_ack = 0;
        p_rst = 1;
        p_adr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                checks++;
                if (block !== 1'b1) begin
                    errors++;
                    $display("FAIL block_in_reset: got %b expected 1", block);
                end
            end else if (!fetch_en) begin
                checks++;
                if (block !== 1'b0 || data !== 16'h0000) begin
                    errors++;
                    $display("FAIL idle_outputs: block=%b data=%h expected block=0 data=0000", block, data);
                end
            end else if (!block) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_accept: pc=%h data=%h with no request pending", pc, data);
                end else begin
                    e = exp_q.pop_front();
                    if (data !== e) begin
                        errors++;
                        $display("FAIL fetch_data pc=%h bf=%b: got %h expected %h", pc, bytefetch, data, e);
                    end
                end
            end
            checks++;
            if (wb.wb_stb_o !== wb.wb_cyc_o || wb.wb_sel_o !== 2'b11) begin
                errors++;
                $display("FAIL wb_static: stb=%b cyc=%b sel=%b expected stb=cyc sel=11",
                         wb.wb_stb_o, wb.wb_cyc_o, wb.wb_sel_o);
            end
            if (p_cyc && !p_ack && !p_rst) begin
                checks++;
                if (wb.wb_cyc_o !== 1'b1 || wb.wb_adr_o !== p_adr) begin
                    errors++;
                    $display("FAIL wb_hold: cyc=%b adr=%h expected cyc=1 adr=%h",
                             wb.wb_cyc_o, wb.wb_adr_o, p_adr);
                end
            end
            p_cyc = wb.wb_cyc_o;
            p_ack = wb.wb_ack_i;
            p_rst = rst;
            p_adr = wb.wb_adr_o;
        end
    end

    // One fetch request, held until accepted; ends with fetch_en low at posedge+1.
    task automatic do_fetch(input logic [19:0] a, input bit bf, output int waits);
        exp_q.push_back(model(a, bf));
        fetch_en  = 1'b1;
        pc        = a;
        bytefetch = bf;
        waits     = 0;
        forever begin
            @(negedge clk);
            if (!block) break;
            waits++;
            if (waits > 300) begin
                checks++;
                errors++;
                $display("FAIL fetch_timeout pc=%h: block still 1 after %0d cycles", a, waits);
                void'(exp_q.pop_back());
                break;
            end
        end
        @(posedge clk);
        #1;
        fetch_en = 1'b0;
    endtask

    task automatic idle(input int n);
        fetch_en = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_flush(input bit change_mem, input logic [19:0] near);
        fetch_en = 1'b0;
        flush    = 1'b1;
        if (change_mem) begin
            for (int k = 0; k < 3; k++) mem_ovr[19'(near[19:1] + 19'(k))] = 16'($urandom);
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic wait_bus_idle();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (!wb.wb_cyc_o && !wb.wb_ack_i) break;
            n++;
            if (n > 100) begin
                checks++;
                errors++;
                $display("FAIL bus_idle_timeout: cyc still %b after %0d cycles", wb.wb_cyc_o, n);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (wb.wb_cyc_o) break;
            n++;
            if (n > 100) begin
                checks++;
                errors++;
                $display("FAIL cyc_start_timeout: no bus cycle after %0d cycles", n);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int          w;
        int          total;
        logic [19:0] pc_r;
        bit          bf;
        int          r;

        rst       = 1'b1;
        fetch_en  = 1'b0;
        pc        = '0;
        bytefetch = 1'b0;
        flush     = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_cyc", 32'(wb.wb_cyc_o), 32'd0);
        check_eq("rst_adr", 32'(wb.wb_adr_o), 32'd0);
        check_eq("rst_block", 32'(block), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Byte fetch near the top of memory
        mem_ovr[19'h7FFF8] = 16'hEA90;
        rd_log.delete();
        lat = 0;
        do_fetch(20'hFFFF0, 1'b1, w);
        check_eq("t1_adr", log_at(0), 32'h7FFF8);
        check_eq("t1_const", 32'(model(20'hFFFF0, 1'b1)), 32'h0090);

        // Odd word fetch on a cold buffer: two bus cycles
        do_flush(1'b0, 20'h0);
        wait_bus_idle();
        rd_log.delete();
        mem_ovr[19'h00080] = 16'h3412;
        mem_ovr[19'h00081] = 16'h7856;
        do_fetch(20'h00101, 1'b0, w);
        check_eq("t2_adr0", log_at(0), 32'h00080);
        check_eq("t2_adr1", log_at(1), 32'h00081);
        check_eq("t2_const", 32'(model(20'h00101, 1'b0)), 32'h5634);

        // Sequential bytes with prefetch: no block after the first fill, slide at 0x202
        do_flush(1'b0, 20'h0);
        wait_bus_idle();
        rd_log.delete();
        lat   = 0;
        total = 0;
        for (int a = 'h200; a <= 'h203; a++) begin
            do_fetch(20'(a), 1'b1, w);
            if (a > 'h200) total += w;
        end
        idle(8);
        check_eq("t3_no_block", 32'(total), 32'd0);
        check_eq("t3_nreads", 32'(rd_log.size()), 32'd3);
        check_eq("t3_adr2_after_slide", log_at(2), 32'h00102);

        // Flush while a read is outstanding: cycle completes, data dropped, fresh read
        do_flush(1'b0, 20'h0);
        wait_bus_idle();
        rd_log.delete();
        lat       = 3;
        fetch_en  = 1'b1;
        pc        = 20'h00400;
        bytefetch = 1'b0;
        wait_cyc();
        do_flush(1'b1, 20'h00400);
        @(negedge clk);
        check_eq("t4_cyc_held", 32'(wb.wb_cyc_o), 32'd1);
        @(posedge clk);
        #1;
        do_fetch(20'h00400, 1'b0, w);
        check_eq("t4_adr0", log_at(0), 32'h00200);
        check_eq("t4_adr1_refetch", log_at(1), 32'h00200);

        // Word fetch across the top of the address space
        idle(2);
        do_flush(1'b0, 20'h0);
        wait_bus_idle();
        rd_log.delete();
        lat = 1;
        do_fetch(20'hFFFFF, 1'b0, w);
        check_eq("t5_adr0", log_at(0), 32'h7FFFF);
        check_eq("t5_adr1_wrap", log_at(1), 32'h00000);

        // Reset during a bus cycle
        idle(2);
        do_flush(1'b0, 20'h0);
        wait_bus_idle();
        lat = 3;
        do_fetch(20'h00000, 1'b0, w);
        wait_cyc();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("t6_cyc", 32'(wb.wb_cyc_o), 32'd0);
        check_eq("t6_stb", 32'(wb.wb_stb_o), 32'd0);
        check_eq("t6_block", 32'(block), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_fetch(20'h00000, 1'b0, w);
        check_eq("t6_refetch_missed", 32'(w > 0), 32'd1);

        // Randomized stream: sequential runs, jumps with flush, idle gaps
        pc_r = 20'($urandom);
        for (int i = 0; i < 400; i++) begin
            r   = $urandom_range(0, 99);
            lat = $urandom_range(0, 3);
            if (r < 10) begin
                case ($urandom_range(0, 2))
                    0:       pc_r = pc_r + 20'($urandom_range(0, 15)) - 20'd8;
                    1:       pc_r = 20'hFFFF0 + 20'($urandom_range(0, 15));
                    default: pc_r = 20'($urandom);
                endcase
                do_flush($urandom_range(0, 1) == 1, pc_r);
            end else if (r < 22) begin
                idle($urandom_range(1, 4));
            end
            bf = ($urandom_range(0, 1) == 1);
            do_fetch(pc_r, bf, w);
            pc_r = pc_r + (bf ? 20'd1 : 20'd2);
        end

        idle(10);
        check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
